control_path_mc: RTL
====================

// Module: control_path_mc
// PURPOSE
//  Parametrised multi-cycle control path for the single-issue CPU: PC, instruction
//  register, FSM and decode in one block. Adds over the 2-state fetch/execute design:
//  req/ack memory handshake with wait states, load/store memory cycle, flag-selected
//  conditional branch, register jump and halt. Drives the datapath (DR/SA/SB/FS/MB/MD/RW)
//  and memory (MM/MW/mem_req, PC).
// PARAMETERS
//  OPW       4       opcode width, IR[DW-1 -: OPW]
//  RAW       4       register-address width (DR, SA, SB fields)
//  DW        16      instruction width; must equal OPW+3*RAW
//  PCW       16      program-counter/address width
//  RESET_PC  0       PC value loaded by reset
// PORTS
//  clk_main  in   1        system clock, rising edge
//  reset     in   1        asynchronous, active-low reset
//  DataIn    in   DW       memory read data (instruction fetch)
//  BusA      in   PCW      datapath A bus (jump target / load-store address)
//  V,C,N,Z   in   1 each   datapath status flags, stable during EXEC
//  mem_ack   in   1        memory transfer complete; sampled only while mem_req=1
//  mem_req   out  1        memory transfer request
//  PC        out  PCW      program counter (fetch address when MM=1)
//  DR,SA,SB  out  RAW      IR fields [3R-1:2R],[2R-1:R],[R-1:0] (R=RAW)
//  FS        out  4        ALU function select
//  MB,MM,MD  out  1 each   B-constant, memory-address (1=PC), load-data muxes
//  MW,RW     out  1 each   memory write, register-file write
//  halted    out  1        processor in HALT
// BEHAVIOUR
//  Reset (reset=0, async): state=INIT, PC=RESET_PC, IR=0; all outputs 0 (DR/SA/SB=0).
//  States: INIT -> FETCH (unconditional, 1 cycle; outputs all 0).
//  FETCH: mem_req=1, MM=1. Each edge with mem_ack=1: IR<=DataIn, PC<=PC+1, ->EXEC.
//   mem_ack=1 in first FETCH cycle = zero-wait; min fetch 1 cycle.
//  EXEC (1 cycle unless memory op), decode on IR opcode:
//   0x0-0x7 ALU reg:  FS={0,op[2:0]}, MB=0, RW=1 -> FETCH
//   0x8 ALU imm:      FS=4'b0010, MB=1 (SB zero-extended constant), RW=1 -> FETCH
//   0x9 LD, 0xA ST:   -> MEM (no strobes in EXEC)
//   0xB Bcc: cond = DR[1:0] 00:Z 01:N 10:C 11:V; if true PC<=PC+sext({SA,SB}) -> FETCH
//   0xC JMP:          PC<=BusA -> FETCH
//   0xD,0xE:          NOP -> FETCH
//   0xF HLT:          -> HALT
//  MEM: mem_req=1, MM=0 (address BusA, SA selects). LD: MD=1, RW=1 asserted only in the
//   cycle mem_ack=1. ST: MW=1 every MEM cycle. On mem_ack edge -> FETCH.
//  HALT: halted=1, mem_req=0, all strobes 0; exits only by reset.
//  Control outputs are combinational from state and IR; PC/IR/state change only on edges.
//  RW, MW, MD, MB, FS nonzero only in EXEC/MEM as listed; 0 in INIT/FETCH/HALT.
//  PC arithmetic modulo 2^PCW (0xFFFF+1 = 0x0000); branch offset 2*RAW bits sign-extended,
//   relative to already-incremented PC.
//  mem_ack while mem_req=0 ignored. Reset mid-transaction abandons it: mem_req/MW drop
//   immediately, no IR/PC/register update.
//  Flags sampled combinationally in the Bcc EXEC cycle only.
// TESTING
//  Reset, zero-wait ack, IR=0x0123 -> INIT,FETCH,EXEC; EXEC: RW=1,FS=0,DR=1,SA=2,SB=3; PC=1.
//  Fetch, ack after 3 waits -> mem_req=1,MM=1 for 4 cycles; IR/PC unchanged until ack edge.
//  LD 0x9450, ack after 2 MEM cycles -> MM=0, mem_req=1; MD=RW=1 only in ack cycle; ST 0xA450 -> MW=1 all MEM cycles.
//  Bcc 0xB0FE fetched at PC=5: Z=1 -> PC=4; Z=0 -> PC=6; DR=3 with V=1 also branches.
//  PC=0xFFFF fetch -> PC=0x0000; JMP 0xC000 with BusA=0x1234 -> PC=0x1234.
//  HLT 0xF000 -> halted=1, mem_req=0 forever; reset low during LD wait -> outputs 0 at once, PC=0.

Source files
------------

// File: rtl/control_path_mc.sv
// Multi-cycle control path for the single-issue CPU: program counter, instruction
// register, sequencing FSM and instruction decode. A req/ack handshake with the
// memory lets instruction fetches and load/store transfers take wait states.
module control_path_mc #(
   parameter int             OPW      = 4,
   parameter int             RAW      = 4,
   parameter int             DW       = 16,
   parameter int             PCW      = 16,
   parameter logic [PCW-1:0] RESET_PC = '0
) (
   input  logic           clk_main,
   input  logic           reset,
   input  logic [DW-1:0]  DataIn,
   input  logic [PCW-1:0] BusA,
   input  logic           V,
   input  logic           C,
   input  logic           N,
   input  logic           Z,
   input  logic           mem_ack,
   output logic           mem_req,
   output logic [PCW-1:0] PC,
   output logic [RAW-1:0] DR,
   output logic [RAW-1:0] SA,
   output logic [RAW-1:0] SB,
   output logic [3:0]     FS,
   output logic           MB,
   output logic           MM,
   output logic           MD,
   output logic           MW,
   output logic           RW,
   output logic           halted
);

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   localparam logic [OPW-1:0] OP_ALU_LAST = OPW'(7);
   localparam logic [OPW-1:0] OP_ALUI     = OPW'(8);
   localparam logic [OPW-1:0] OP_LD       = OPW'(9);
   localparam logic [OPW-1:0] OP_ST       = OPW'(10);
   localparam logic [OPW-1:0] OP_BCC      = OPW'(11);
   localparam logic [OPW-1:0] OP_JMP      = OPW'(12);
   localparam logic [OPW-1:0] OP_HLT      = OPW'(15);

   state_t           state;
   state_t           state_nxt;
   logic [DW-1:0]    ir;
   logic [PCW-1:0]   pc;
   logic [OPW-1:0]   op;
   logic [2*RAW-1:0] br_off;
   logic [PCW-1:0]   br_target;
   logic             br_taken;

   assign op     = ir[DW-1 -: OPW];
   assign DR     = ir[3*RAW-1 -: RAW];
   assign SA     = ir[2*RAW-1 -: RAW];
   assign SB     = ir[RAW-1:0];
   assign PC     = pc;

   // Branch offset is the SA:SB pair, sign-extended and added to the already-incremented PC.
   assign br_off    = {SA, SB};
   assign br_target = pc + {{(PCW-2*RAW){br_off[2*RAW-1]}}, br_off};

   // Condition select: the low two bits of the DR field pick one status flag.
   always_comb begin
      case (DR[1:0])
         2'b00:   br_taken = Z;
         2'b01:   br_taken = N;
         2'b10:   br_taken = C;
         default: br_taken = V;
      endcase
   end

   // State register.
   always_ff @(posedge clk_main or negedge reset) begin
      // NOTE: sequential state is written with non-blocking assignments only, so every
      // register samples pre-edge values regardless of block ordering.
      if (!reset) state <= S_INIT;
      else        state <= state_nxt;
   end

   // Next-state logic: fetch and memory states hold until the ack edge.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  state_nxt = S_FETCH;
         S_FETCH: if (mem_ack) state_nxt = S_EXEC;
         S_EXEC: begin
            if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
            else if (op == OP_HLT)          state_nxt = S_HALT;
            else                            state_nxt = S_FETCH;
         end
         S_MEM:   if (mem_ack) state_nxt = S_FETCH;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_INIT;
      endcase
   end

   // PC and IR: IR loads on the fetch ack edge; branches and jumps redirect PC in EXEC.
   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
         ir <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ack) begin
                  ir <= DataIn;
                  pc <= pc + PCW'(1);
               end
            end
            S_EXEC: begin
               if (op == OP_BCC && br_taken) pc <= br_target;
               else if (op == OP_JMP)        pc <= BusA;
            end
            default: ;
         endcase
      end
   end

   // Control outputs decoded from state and IR opcode.
   always_comb begin
      // NOTE: every output gets a default before the case, so no path leaves one
      // unassigned and no latch is inferred.
      mem_req = 1'b0;
      MM      = 1'b0;
      MW      = 1'b0;
      MD      = 1'b0;
      RW      = 1'b0;
      MB      = 1'b0;
      FS      = 4'b0000;
      halted  = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            MM      = 1'b1;
         end
         S_EXEC: begin
            if (op <= OP_ALU_LAST) begin
               FS = {1'b0, op[2:0]};
               RW = 1'b1;
            end else if (op == OP_ALUI) begin
               FS = 4'b0010;
               MB = 1'b1;
               RW = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (op == OP_LD) begin
               MD = mem_ack;
               RW = mem_ack;
            end
            if (op == OP_ST) MW = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule
